// File: rtl/axis_pkt_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen_if
// Brief    : AXI-Stream bus bundle carried from the packet generator to its sink.
// Revision : 1.0
// ============================================================================
interface axis_pkt_gen_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata, tkeep, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tlast, tvalid,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen
// Brief    : Replays a stored multi-beat frame template as AXI-Stream bursts with
//            programmable count and gap. Macro SEQ_INSERT_EN stamps a big-endian
//            32-bit sequence number into beat 0 at byte SEQ_OFFSET.
// Revision : 1.0
// ============================================================================
module axis_pkt_gen #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int TMPL_DEPTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int SEQ_OFFSET = 46
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tmpl_wr_en,
    input  logic [$clog2(TMPL_DEPTH)-1:0]   tmpl_wr_addr,
    input  logic [DATA_WIDTH-1:0]           tmpl_wr_data,
    input  logic [KEEP_WIDTH-1:0]           tmpl_wr_keep,
    output logic                            tmpl_wr_ready,
    input  logic [$clog2(TMPL_DEPTH):0]     cfg_len,
    input  logic [CNT_WIDTH-1:0]            cfg_count,
    input  logic [CNT_WIDTH-1:0]            cfg_gap,
    input  logic [USER_WIDTH-1:0]           cfg_user,
    input  logic                            start,
    input  logic                            stop,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_WIDTH-1:0]            pkt_cnt,
    axis_pkt_gen_if.master                  m_axis
);
    localparam int AW = $clog2(TMPL_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // The offset must fit even when stamping is compiled out, so flipping the macro never changes legality.
    if (SEQ_OFFSET > KEEP_WIDTH - 4) begin : g_seq_offset_check
        $error("SEQ_OFFSET does not leave room for a 32-bit field in beat 0");
    end

    logic [DATA_WIDTH-1:0] mem_data [TMPL_DEPTH];
    logic [KEEP_WIDTH-1:0] mem_keep [TMPL_DEPTH];

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [AW-1:0]         r_len_m1;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_gap;
    logic [CNT_WIDTH-1:0]  r_gap_cnt;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_stop;
    logic [AW-1:0]         r_beat;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KEEP_WIDTH-1:0] r_tkeep;
    logic                  r_tlast;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic                  r_done;

    logic                  w_hs;
    logic                  w_pkt_end;
    logic                  w_stop_seen;
    logic                  w_count_hit;
    logic                  w_gap_last;
    logic                  w_burst_end;
    logic                  w_load;
    logic [AW-1:0]         w_rd_idx;
    logic [AW-1:0]         w_len_m1;
    logic [CNT_WIDTH-1:0]  w_pkt_cnt_inc;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic                  w_tvalid;
    logic                  w_busy;
    logic                  w_wr_ready;

    assign w_hs          = (r_state == S_SEND) && m_axis.tready;
    assign w_pkt_end     = w_hs && r_tlast;
    assign w_stop_seen   = r_stop || stop;
    assign w_pkt_cnt_inc = r_pkt_cnt + 1'b1;
    assign w_count_hit   = (r_count != '0) && (w_pkt_cnt_inc == r_count);
    assign w_gap_last    = (r_gap_cnt == '0);
    assign w_burst_end   = (w_pkt_end && (w_count_hit || w_stop_seen)) ||
                           ((r_state == S_GAP) && w_stop_seen);
    // The output register doubles as the RAM read register: the address is the beat needed after this edge.
    assign w_load        = (r_state == S_LOAD) || w_hs;
    assign w_rd_idx      = (w_hs && !r_tlast) ? r_beat + 1'b1 : '0;

    always_comb begin
        if (cfg_len == '0) begin
            w_len_m1 = '0;
        end else if (cfg_len > LW'(TMPL_DEPTH)) begin
            w_len_m1 = AW'(TMPL_DEPTH - 1);
        end else begin
            w_len_m1 = AW'(cfg_len - 1'b1);
        end
    end

`ifdef SEQ_INSERT_EN
    logic [31:0] w_seq;

    // Beat 0 is fetched either in LOAD (count already cleared) or on the tlast handshake that bumps the count.
    assign w_seq = 32'(w_pkt_end ? w_pkt_cnt_inc : r_pkt_cnt);

    always_comb begin
        w_beat_data = mem_data[w_rd_idx];
        if (w_rd_idx == '0) begin
            w_beat_data[8*SEQ_OFFSET +: 32] = {w_seq[7:0], w_seq[15:8], w_seq[23:16], w_seq[31:24]};
        end
    end
`else
    assign w_beat_data = mem_data[w_rd_idx];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = S_SEND;
            S_SEND: begin
                if (w_pkt_end) begin
                    if (w_burst_end)        w_state_nxt = S_IDLE;
                    else if (r_gap != '0)   w_state_nxt = S_GAP;
                    else                    w_state_nxt = S_SEND;
                end
            end
            S_GAP: begin
                if (w_stop_seen)            w_state_nxt = S_IDLE;
                else if (w_gap_last)        w_state_nxt = S_SEND;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tvalid   = 1'b0;
        w_busy     = 1'b1;
        w_wr_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy     = 1'b0;
                w_wr_ready = 1'b1;
            end
            S_SEND:  w_tvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tmpl_wr_en && w_wr_ready) begin
            mem_data[tmpl_wr_addr] <= tmpl_wr_data;
            mem_keep[tmpl_wr_addr] <= tmpl_wr_keep;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len_m1  <= '0;
            r_count   <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_user    <= '0;
            r_stop    <= 1'b0;
            r_beat    <= '0;
            r_tdata   <= '0;
            r_tkeep   <= '0;
            r_tlast   <= 1'b0;
            r_pkt_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_burst_end;

            if (r_state == S_IDLE) begin
                if (start) begin
                    r_len_m1  <= w_len_m1;
                    r_count   <= cfg_count;
                    r_gap     <= cfg_gap;
                    r_user    <= cfg_user;
                    r_pkt_cnt <= '0;
                    r_stop    <= 1'b0;
                end
            end else if (stop) begin
                r_stop <= 1'b1;
            end

            if (w_pkt_end) begin
                r_pkt_cnt <= w_pkt_cnt_inc;
            end

            if (w_load) begin
                r_beat  <= w_rd_idx;
                r_tdata <= w_beat_data;
                r_tkeep <= mem_keep[w_rd_idx];
                r_tlast <= (w_rd_idx == r_len_m1);
            end

            if (w_pkt_end && !w_burst_end && (r_gap != '0)) begin
                r_gap_cnt <= r_gap - 1'b1;
            end else if ((r_state == S_GAP) && !w_gap_last) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tkeep  = r_tkeep;
    assign m_axis.tuser  = r_user;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tvalid = w_tvalid;

    assign tmpl_wr_ready = w_wr_ready;
    assign busy          = w_busy;
    assign done          = r_done;
    assign pkt_cnt       = r_pkt_cnt;
endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_gen
// Brief    : Scoreboard bench for axis_pkt_gen: a frame-level model fills an
//            expectation queue, a monitor checks every accepted or stalled beat.
// Revision : 1.0
// ============================================================================
module tb_axis_pkt_gen;
    localparam int DW    = 128;
    localparam int KW    = 16;
    localparam int UW    = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int LW    = AW + 1;
    localparam int CW    = 16;
    localparam int SOFF  = 6;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tmpl_wr_en;
    logic [AW-1:0] tmpl_wr_addr;
    logic [DW-1:0] tmpl_wr_data;
    logic [KW-1:0] tmpl_wr_keep;
    logic          tmpl_wr_ready;
    logic [LW-1:0] cfg_len;
    logic [CW-1:0] cfg_count;
    logic [CW-1:0] cfg_gap;
    logic [UW-1:0] cfg_user;
    logic          start;
    logic          stop;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkt_cnt;

    axis_pkt_gen_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) axis ();

    axis_pkt_gen #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
        .TMPL_DEPTH(DEPTH), .CNT_WIDTH(CW), .SEQ_OFFSET(SOFF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tmpl_wr_en(tmpl_wr_en), .tmpl_wr_addr(tmpl_wr_addr),
        .tmpl_wr_data(tmpl_wr_data), .tmpl_wr_keep(tmpl_wr_keep),
        .tmpl_wr_ready(tmpl_wr_ready),
        .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_user(cfg_user),
        .start(start), .stop(stop), .busy(busy), .done(done), .pkt_cnt(pkt_cnt),
        .m_axis(axis)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] tmpl_data [DEPTH];
    logic [KW-1:0] tmpl_keep [DEPTH];
    beat_t         exp_q [$];
    int            hs_cyc [$];
    int            n_checks  = 0;
    int            n_fail    = 0;
    int            cyc       = 0;
    int            acc_beats = 0;
    int            done_cnt  = 0;
    int            rdy_mode  = 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_len(input int len);
        if (len == 0)     return 1;
        if (len > DEPTH)  return DEPTH;
        return len;
    endfunction

    // Frame-level model: each packet is the template prefix, beat 0 optionally stamped.
    task automatic push_packets(input int len, input int npkt, input logic [UW-1:0] user);
        int n = eff_len(len);
        for (int p = 0; p < npkt; p++) begin
            for (int b = 0; b < n; b++) begin
                beat_t e;
                e.data = tmpl_data[b];
                e.keep = tmpl_keep[b];
                e.last = (b == n - 1);
                e.user = user;
`ifdef SEQ_INSERT_EN
                if (b == 0) begin
                    logic [31:0] s;
                    s = 32'(p);
                    for (int k = 0; k < 4; k++) e.data[8*(SOFF+k) +: 8] = s[8*(3-k) +: 8];
                end
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic write_template();
        for (int b = 0; b < DEPTH; b++) begin
            tmpl_data[b] = {$urandom, $urandom, $urandom, $urandom};
            tmpl_keep[b] = KW'($urandom);
            tmpl_wr_en   = 1'b1;
            tmpl_wr_addr = AW'(b);
            tmpl_wr_data = tmpl_data[b];
            tmpl_wr_keep = tmpl_keep[b];
            tick();
        end
        tmpl_wr_en = 1'b0;
    endtask

    task automatic start_burst(input int len, input int count, input int gap, input int user, input int npkt);
        cfg_len   = LW'(len);
        cfg_count = CW'(count);
        cfg_gap   = CW'(gap);
        cfg_user  = UW'(user);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        push_packets(len, npkt, UW'(user));
        @(negedge clk);
        check("load_tvalid",  DW'(axis.tvalid), DW'(0));
        check("load_busy",    DW'(busy),        DW'(1));
        check("load_pkt_cnt", DW'(pkt_cnt),     DW'(0));
        @(negedge clk);
        check("first_tvalid", DW'(axis.tvalid), DW'(1));
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int i  = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        repeat (3) tick();
        check({name, "_done_pulses"}, DW'(done_cnt - d0), DW'(1));
        check({name, "_busy"},        DW'(busy),          DW'(0));
    endtask

    task automatic wait_beats(input int target, input int budget);
        int i = 0;
        while (acc_beats < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("wait_beats_reached", DW'(acc_beats >= target), DW'(1));
    endtask

    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       axis.tready = 1'b0;
                1:       axis.tready = 1'b1;
                2:       axis.tready = ~axis.tready;
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1) begin
                if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got beat data %0h required no beat", axis.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", axis.tdata,       e.data);
                        check("beat_keep", DW'(axis.tkeep),  DW'(e.keep));
                        check("beat_last", DW'(axis.tlast),  DW'(e.last));
                        check("beat_user", DW'(axis.tuser),  DW'(e.user));
                    end
                    hs_cyc.push_back(cyc);
                    acc_beats++;
                end else if (axis.tvalid === 1'b1 && exp_q.size() != 0) begin
                    check("stall_data", axis.tdata,      exp_q[0].data);
                    check("stall_last", DW'(axis.tlast), DW'(exp_q[0].last));
                end
                if (done === 1'b1) done_cnt++;
            end
        end
    end

    initial begin
        int h0;
        int a0;
        rst_n        = 1'b0;
        tmpl_wr_en   = 1'b0;
        tmpl_wr_addr = '0;
        tmpl_wr_data = '0;
        tmpl_wr_keep = '0;
        cfg_len      = '0;
        cfg_count    = '0;
        cfg_gap      = '0;
        cfg_user     = '0;
        start        = 1'b0;
        stop         = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tvalid",   DW'(axis.tvalid),   DW'(0));
        check("rst_tlast",    DW'(axis.tlast),    DW'(0));
        check("rst_tdata",    axis.tdata,         DW'(0));
        check("rst_tkeep",    DW'(axis.tkeep),    DW'(0));
        check("rst_tuser",    DW'(axis.tuser),    DW'(0));
        check("rst_busy",     DW'(busy),          DW'(0));
        check("rst_done",     DW'(done),          DW'(0));
        check("rst_pkt_cnt",  DW'(pkt_cnt),       DW'(0));
        check("rst_wr_ready", DW'(tmpl_wr_ready), DW'(1));
        tick();
        rst_n = 1'b1;
        tick();
        write_template();

        // Two-beat frames, three packets, always ready: six contiguous beats.
        rdy_mode = 1;
        h0 = hs_cyc.size();
        start_burst(2, 3, 0, 1, 3);
        wait_done("t1", 200);
        check("t1_pkt_cnt", DW'(pkt_cnt), DW'(3));
        check("t1_beats", DW'(hs_cyc.size() - h0), DW'(6));
        check("t1_contig", DW'((hs_cyc.size() > h0) ? hs_cyc[$] - hs_cyc[h0] : -1), DW'(5));

        // Same with toggling ready; writes and restarts while busy must be ignored.
        rdy_mode = 2;
        h0 = hs_cyc.size();
        start_burst(2, 3, 0, 2, 3);
        check("t2_wr_ready_busy", DW'(tmpl_wr_ready), DW'(0));
        tmpl_wr_en   = 1'b1;
        tmpl_wr_addr = '0;
        tmpl_wr_data = ~tmpl_data[0];
        tmpl_wr_keep = ~tmpl_keep[0];
        cfg_len      = LW'(1);
        cfg_count    = CW'(1);
        start        = 1'b1;
        tick();
        tmpl_wr_en   = 1'b0;
        start        = 1'b0;
        wait_done("t2", 300);
        check("t2_pkt_cnt", DW'(pkt_cnt), DW'(3));
        check("t2_beats", DW'(hs_cyc.size() - h0), DW'(6));

        // Single-beat frames separated by a four-cycle gap.
        rdy_mode = 1;
        h0 = hs_cyc.size();
        start_burst(1, 2, 4, 0, 2);
        wait_done("t3", 200);
        check("t3_pkt_cnt", DW'(pkt_cnt), DW'(2));
        check("t3_gap", DW'((hs_cyc.size() > h0 + 1) ? hs_cyc[h0+1] - hs_cyc[h0] : -1), DW'(5));

        // Continuous mode, stop raised mid-packet 6: that packet completes.
        a0 = acc_beats;
        start_burst(4, 0, 0, 3, 10);
        wait_beats(a0 + 21, 500);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t4", 200);
        check("t4_pkt_cnt", DW'(pkt_cnt), DW'(6));
        check("t4_leftover", DW'(exp_q.size()), DW'(16));
        exp_q.delete();

        // Stop during an inter-packet gap ends the burst with no further beats.
        a0 = acc_beats;
        start_burst(1, 0, 5, 0, 3);
        wait_beats(a0 + 1, 200);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t4g", 200);
        check("t4g_pkt_cnt", DW'(pkt_cnt), DW'(1));
        check("t4g_leftover", DW'(exp_q.size()), DW'(2));
        exp_q.delete();

        // Reset while a beat is stalled, then replay from beat 0.
        a0 = acc_beats;
        start_burst(4, 0, 0, 1, 2);
        wait_beats(a0 + 5, 200);
        tick();
        rdy_mode = 0;
        repeat (3) tick();
        check("t5_stalled_tvalid", DW'(axis.tvalid), DW'(1));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_tvalid",   DW'(axis.tvalid),   DW'(0));
        check("t5_busy",     DW'(busy),          DW'(0));
        check("t5_pkt_cnt",  DW'(pkt_cnt),       DW'(0));
        check("t5_wr_ready", DW'(tmpl_wr_ready), DW'(1));
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        rdy_mode = 1;
        tick();
        start_burst(3, 1, 0, 2, 1);
        wait_done("t5r", 200);
        check("t5r_pkt_cnt", DW'(pkt_cnt), DW'(1));

        // Length boundaries: zero means one beat, oversize clamps to the depth.
        rdy_mode = 3;
        start_burst(0, 2, 1, 1, 2);
        wait_done("len0", 300);
        check("len0_pkt_cnt", DW'(pkt_cnt), DW'(2));
        start_burst(12, 2, 0, 3, 2);
        wait_done("lenmax", 300);
        check("lenmax_pkt_cnt", DW'(pkt_cnt), DW'(2));

        for (int r = 0; r < 6; r++) begin
            int len   = $urandom_range(1, DEPTH);
            int count = $urandom_range(1, 4);
            if (r == 3) write_template();
            rdy_mode = $urandom_range(1, 3);
            start_burst(len, count, $urandom_range(0, 3), $urandom_range(0, 3), count);
            wait_done("rand", 1000);
            check("rand_pkt_cnt", DW'(pkt_cnt), DW'(count));
        end

        check("queue_drained", DW'(exp_q.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
